// File: rtl/main_road_controller.sv
// Main-road signal controller: holds main green, and on a side-road request runs
// main yellow -> main red with side_grant -> all-red clearance -> main green.
module main_road_controller #(
  parameter int MIN_GREEN    = 4,
  parameter int YELLOW_TIME  = 2,
  parameter int MAX_RED_TIME = 8,
  parameter int ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       side_done,
  output logic       R1,
  output logic       Y1,
  output logic       G1,
  output logic       side_grant,
  output logic [1:0] present_state
);

  localparam logic [1:0] S_MAIN_GREEN  = 2'b00;
  localparam logic [1:0] S_MAIN_YELLOW = 2'b01;
  localparam logic [1:0] S_RED_GRANT   = 2'b10;
  localparam logic [1:0] S_ALL_RED     = 2'b11;

  // Last count value of each timed state (durations are in cycles, count starts at 0).
  localparam logic [3:0] GREEN_LAST  = 4'(MIN_GREEN - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TIME - 1);
  localparam logic [3:0] RED_LAST    = 4'(MAX_RED_TIME - 1);
  localparam logic [3:0] ALLRED_LAST = 4'(ALL_RED_TIME - 1);
  localparam logic [3:0] COUNT_MAX   = 4'd15;

  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       pending_q, pending_d;
  logic       state_change;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_GREEN:
        if ((car_sensor || pending_q) && (count_q >= GREEN_LAST))
          state_d = S_MAIN_YELLOW;
      S_MAIN_YELLOW:
        if (count_q == YELLOW_LAST)
          state_d = S_RED_GRANT;
      S_RED_GRANT:
        if (side_done || (count_q == RED_LAST))
          state_d = S_ALL_RED;
      S_ALL_RED:
        if (count_q == ALLRED_LAST)
          state_d = S_MAIN_GREEN;
      default:
        state_d = S_MAIN_GREEN;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Dwell counter restarts on every state change and saturates instead of wrapping,
  // so a long idle green still reads as "minimum green satisfied".
  always_comb begin
    count_d = count_q;
    if (state_change)
      count_d = '0;
    else if (count_q != COUNT_MAX)
      count_d = count_q + 4'd1;
  end

  // The request is consumed when the grant is actually issued; that clear beats
  // a simultaneous new request so a car still present cannot re-arm it here.
  always_comb begin
    pending_d = pending_q;
    if ((state_q == S_MAIN_YELLOW) && (state_d == S_RED_GRANT))
      pending_d = 1'b0;
    else if (car_sensor && (state_q != S_RED_GRANT))
      pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_MAIN_GREEN;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    G1         = 1'b0;
    Y1         = 1'b0;
    R1         = 1'b0;
    side_grant = 1'b0;
    case (state_q)
      S_MAIN_GREEN:  G1 = 1'b1;
      S_MAIN_YELLOW: Y1 = 1'b1;
      S_RED_GRANT: begin
        R1         = 1'b1;
        side_grant = 1'b1;
      end
      S_ALL_RED:     R1 = 1'b1;
      default:       G1 = 1'b1;
    endcase
  end

  assign present_state = state_q;

endmodule

// File: tb/tb_main_road_controller.sv
// Bench for main_road_controller: fixed vector table, directed corner sequences,
// and randomized traffic checked against a phase/elapsed-time reference model.
module tb_main_road_controller;

  localparam int MIN_GREEN    = 4;
  localparam int YELLOW_TIME  = 2;
  localparam int MAX_RED_TIME = 8;
  localparam int ALL_RED_TIME = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_sensor = 1'b0;
  logic       side_done = 1'b0;
  logic       R1, Y1, G1, side_grant;
  logic [1:0] present_state;

  main_road_controller #(
    .MIN_GREEN   (MIN_GREEN),
    .YELLOW_TIME (YELLOW_TIME),
    .MAX_RED_TIME(MAX_RED_TIME),
    .ALL_RED_TIME(ALL_RED_TIME)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .car_sensor   (car_sensor),
    .side_done    (side_done),
    .R1           (R1),
    .Y1           (Y1),
    .G1           (G1),
    .side_grant   (side_grant),
    .present_state(present_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0=green 1=yellow 2=red+grant 3=all-red, plus
  // unbounded time spent in the phase and a remembered request.
  int m_phase;
  int m_elapsed;
  bit m_req;

  typedef struct {
    bit         car;
    bit         done;
    logic [1:0] st;
    logic [3:0] lamps; // {G1,Y1,R1,side_grant}
  } vec_t;

  vec_t tbl[12];
  int   exp_tmo[16] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 0};

  function automatic void m_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_req     = 1'b0;
  endfunction

  function automatic void m_step(bit car, bit done);
    bit adv;
    case (m_phase)
      0:       adv = (car || m_req) && (m_elapsed >= MIN_GREEN - 1);
      1:       adv = (m_elapsed >= YELLOW_TIME - 1);
      2:       adv = done || (m_elapsed >= MAX_RED_TIME - 1);
      default: adv = (m_elapsed >= ALL_RED_TIME - 1);
    endcase
    if (m_phase == 1 && adv)
      m_req = 1'b0;
    else if (car && m_phase != 2)
      m_req = 1'b1;
    if (adv) begin
      m_phase   = (m_phase + 1) % 4;
      m_elapsed = 0;
    end else begin
      m_elapsed = m_elapsed + 1;
    end
  endfunction

  function automatic logic [10:0] m_expect();
    logic [1:0] ph;
    logic [3:0] cnt;
    ph  = 2'(m_phase);
    cnt = (m_elapsed > 15) ? 4'd15 : 4'(m_elapsed);
    return {ph, (m_phase == 0), (m_phase == 1), (m_phase >= 2), (m_phase == 2), cnt, m_req};
  endfunction

  task automatic cmp(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    cmp(name, {present_state, G1, Y1, R1, side_grant, dut.count_q, dut.pending_q}, m_expect());
  endtask

  task automatic cmp_out(input string name, input logic [1:0] st, input logic [3:0] lamps);
    cmp(name, {5'd0, present_state, G1, Y1, R1, side_grant}, {5'd0, st, lamps});
  endtask

  task automatic tick(input bit c, input bit d);
    car_sensor = c;
    side_done  = d;
    @(posedge clk);
    if (reset) m_step(c, d);
    else       m_reset();
    #1;
    check_model("model");
  endtask

  task automatic apply_reset();
    car_sensor = 1'b0;
    side_done  = 1'b0;
    reset      = 1'b0;
    m_reset();
    #1;
    check_model("reset_model");
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 4'b1000};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 4'b1000};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 4'b1000};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 4'b1000};
    tbl[4]  = '{1'b1, 1'b0, 2'b01, 4'b0100};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 4'b0100};
    tbl[6]  = '{1'b1, 1'b0, 2'b10, 4'b0011};
    tbl[7]  = '{1'b1, 1'b0, 2'b10, 4'b0011};
    tbl[8]  = '{1'b1, 1'b0, 2'b10, 4'b0011};
    tbl[9]  = '{1'b1, 1'b1, 2'b10, 4'b0011};
    tbl[10] = '{1'b1, 1'b0, 2'b11, 4'b0010};
    tbl[11] = '{1'b1, 1'b0, 2'b00, 4'b1000};

    // Reset with no clock edge, then held across three edges.
    #1 reset = 1'b0;
    m_reset();
    #1;
    cmp_out("reset_noclk", 2'b00, 4'b1000);
    cmp("reset_cnt_pend", {6'd0, dut.count_q, dut.pending_q}, 11'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp_out("reset_held", 2'b00, 4'b1000);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Full sequence from the vector table.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cmp_out($sformatf("full_c%0d", i), tbl[i].st, tbl[i].lamps);
      tick(tbl[i].car, tbl[i].done);
    end

    // One-cycle request pulse must be remembered.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cmp_out($sformatf("pulse_c%0d", i), tbl[i].st, tbl[i].lamps);
      if (i >= 2 && i <= 5) cmp($sformatf("pulse_pend_c%0d", i), {10'd0, dut.pending_q}, 11'd1);
      if (i == 6)           cmp("pulse_pend_clr", {10'd0, dut.pending_q}, 11'd0);
      tick(i == 1, i == 9);
    end

    // Grant timeout without side_done.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("tmo_state_c%0d", i), {9'd0, present_state}, 11'(exp_tmo[i]));
      cmp($sformatf("tmo_grant_c%0d", i), {10'd0, side_grant}, {10'd0, (i >= 6 && i <= 13)});
      tick(1'b1, 1'b0);
    end

    // Long idle green: counter saturates, a late request still goes through.
    apply_reset();
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    cmp("sat_count", {7'd0, dut.count_q}, 11'd15);
    cmp_out("sat_state", 2'b00, 4'b1000);
    tick(1'b1, 1'b0);
    cmp_out("late_req", 2'b01, 4'b0100);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    cmp_out("pre_rst_grant", 2'b10, 4'b0011);
    #2 reset = 1'b0;
    m_reset();
    #1;
    cmp_out("rst_mid_grant", 2'b00, 4'b1000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cmp_out($sformatf("post_rst_c%0d", i), 2'b00, 4'b1000);
      else       cmp_out("post_rst_yellow", 2'b01, 4'b0100);
      tick(1'b1, 1'b0);
    end

    // Randomized traffic with occasional asynchronous resets.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b0;
        m_reset();
        #1;
        check_model("rnd_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
      end else begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_road_controller.md
# main_road_controller

Main-road (highway) signal controller: the granting end of the side-road car-request handshake. It holds the main road green by default. When the side-road car sensor requests access and the minimum green time has elapsed, it sequences main yellow, then main red. It asserts `side_grant` to the side-road controller while main is red, and returns to main green after the side road reports completion or a safety timeout expires.

## Interface
- `MIN_GREEN`, 4: minimum main-green cycles before a request is honoured (1..15)
- `YELLOW_TIME`, 2: main-yellow duration in cycles (1..15)
- `MAX_RED_TIME`, 8: maximum `side_grant` duration in cycles before forced return (1..15)
- `ALL_RED_TIME`, 1: all-red clearance cycles after grant ends (1..15)
- `clk` input 1: system clock, all state updates on rising edge
- `reset` input 1: asynchronous, active-low reset (0 = reset)
- `car_sensor` input 1: side-road car present, level, sampled every edge
- `side_done` input 1: side-road controller has finished its green/yellow and is back at red
- `R1` output 1: main-road red lamp
- `Y1` output 1: main-road yellow lamp
- `G1` output 1: main-road green lamp
- `side_grant` output 1: side road permitted to go green
- `present_state` output 2: current FSM state, for debug and display

## Operation
- States (2-bit):
  - S0 MAIN_GREEN = 00
  - S1 MAIN_YELLOW = 01
  - S2 MAIN_RED_GRANT = 10
  - S3 ALL_RED = 11
- Lamp and grant decode (Moore):
  - S0: G1=1.
  - S1: Y1=1.
  - S2: R1=1 and side_grant=1.
  - S3: R1=1 and side_grant=0.
  - Exactly one lamp is high in every state.
- 4-bit `count`:
  - Cleared to 0 on every state transition.
  - Otherwise increments each cycle, saturating at 15 (never wraps).
- `pending` request latch:
  - Set on any edge where car_sensor=1 and state≠S2.
  - Cleared on the S1→S2 transition; clearing has priority over setting in that cycle.
- Transitions, evaluated on the pre-edge values of count, pending and inputs:
  - S0→S1 when (car_sensor | pending) and count ≥ MIN_GREEN−1.
  - S1→S2 when count == YELLOW_TIME−1.
  - S2→S3 when side_done=1 or count == MAX_RED_TIME−1. If both hold, the result is the same transition.
  - S3→S0 when count == ALL_RED_TIME−1.
  - Otherwise the state holds.
- side_done is ignored outside S2.
- Illegal or unreached encodings cannot exist with 2 bits. The default branch of the next-state decode goes to S0.

## Timing
- Reset (asynchronous, reset=0), effective immediately without waiting for a clock edge:
  - present_state=00, count=0, pending=0.
  - G1=1, Y1=0, R1=0, side_grant=0.
- Reset asserted mid-sequence (including S2) forces the above immediately. side_grant drops with no clock edge.
- Outputs are combinational decodes of the registered state: they change in the same cycle as present_state, with zero added latency.
- State durations:
  - S0 lasts at least MIN_GREEN cycles.
  - S1 lasts exactly YELLOW_TIME cycles.
  - S2 lasts 1..MAX_RED_TIME cycles.
  - S3 lasts exactly ALL_RED_TIME cycles.
- side_done is sampled at a rising edge and leaves S2 at that edge. A side_done pulse in S2's first cycle gives a 1-cycle grant.
- A one-cycle car_sensor pulse at any time outside S2 is remembered via pending and is never lost.
- A request in S3 re-triggers the sequence only after a full MIN_GREEN in S0.

## Test plan
- **Reset value:** reset=0, no clock → G1=1, R1=0, Y1=0, side_grant=0, present_state=00. Hold reset for 3 edges → no change.
- **Full sequence, defaults:** reset released before cycle 0; car_sensor=1 constant; side_done pulsed in cycle 9.
  - Cycles 0–3: S0.
  - Cycles 4–5: S1, Y1=1.
  - Cycles 6–9: S2, side_grant=1.
  - Cycle 10: S3.
  - Cycle 11: S0.
- **Request pulse:** car_sensor=1 only in cycle 1 → identical sequence to the full-sequence scenario. pending=0 after the S1→S2 edge (edge at the end of cycle 5).
- **Timeout:** as the full-sequence scenario but side_done never asserted → side_grant high exactly 8 cycles (6–13), S3 at cycle 14, S0 at cycle 15.
- **Saturation, late request:** no car for 40 cycles → stays S0 and count reads 15 (no wrap). car_sensor=1 in cycle 40 → S1 in cycle 41.
- **Reset mid-grant:** reset=0 asserted mid-cycle while in S2 → side_grant=0 and G1=1 immediately. After release, S0 lasts MIN_GREEN cycles even with car_sensor held at 1.
